// File: rtl/tmon_op_arbiter.sv
// tmon_op_arbiter: round-robin sharing of the single tmon opcode channel among NREQ masters,
// one op in flight, with a mon_ready timeout and per-requester done/err pulses.
module tmon_op_arbiter #(
    parameter int  NREQ    = 4,
    parameter type DTYPE   = logic [7:0],
    parameter int  TIMEOUT = 16,
    parameter int  OPW     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0][OPW-1:0]  req_op,
    input  DTYPE [NREQ-1:0]           req_opnd,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic [NREQ-1:0]           err,
    output logic [OPW-1:0]            mon_op,
    output DTYPE                      mon_opnd,
    output logic                      mon_valid,
    input  logic                      mon_ready,
    output logic                      busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [OPW-1:0] NOOP = '0;
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] ptr, cur, pick;
    logic [CW-1:0] cnt;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NREQ);
    endfunction

    // descending scan so the nearest requester at or after ptr wins
    always_comb begin
        pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            pick = req[wrap(int'(ptr) + k)] ? wrap(int'(ptr) + k) : pick;
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            mon_valid <= 1'b0;
            mon_op    <= NOOP;
            mon_opnd  <= '0;
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    gnt      <= NREQ'(1) << pick;
                    cur      <= pick;
                    mon_op   <= req_op[pick];
                    mon_opnd <= req_opnd[pick];
                    if (req_op[pick] == NOOP) begin
                        done[pick] <= 1'b1;
                        state      <= RESP;
                    end else begin
                        mon_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: if (mon_ready) begin
                    mon_valid <= 1'b0;
                    mon_op    <= NOOP;
                    done[cur] <= 1'b1;
                    state     <= RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    mon_valid <= 1'b0;
                    err[cur]  <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    err   <= '0;
                    cnt   <= '0;
                    ptr   <= wrap(int'(cur) + 1);
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
